// File: rtl/tli4970_array_reader_if.sv
// Avalon-MM slave bus bundle for tli4970_array_reader.
//
// Read handshake: the master holds read and address until waitrequest is low.
// waitrequest is high in the first read cycle and low in the second, when
// readdata is valid. Writes complete in the cycle write is high, without
// waiting.
interface tli4970_array_reader_if;
    logic [7:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/tli4970_array_reader.sv
// tli4970_array_reader: sweeps TLI4970 current sensors on a shared SPI bus
// (CPOL=0/CPHA=1, 16 bits, MSB first). Frames are validated and stored per
// sensor and exposed on an Avalon-MM slave.
// Optional macro TLI4970_AVERAGE_EN adds a 4-deep sample history per sensor,
// read at 0x60+i as a signed average.
module tli4970_array_reader #(
    parameter int NUMBER_OF_SENSORS = 4,
    parameter int CLOCK_SPEED_HZ    = 50_000_000,
    parameter int SPI_FREQUENCY_HZ  = 1_000_000,
    parameter int UPDATE_FREQUENCY  = 10_000,
    parameter int CURRENT_OFFSET    = 4096
) (
    input  logic                         clock,
    input  logic                         reset_n,
    tli4970_array_reader_if.slave        avs,
    output logic [NUMBER_OF_SENSORS-1:0] ss_n_o,
    input  logic                         miso,
    output logic                         sck,
    output logic [2:0]                   o_dbg_state
);
    localparam int N    = NUMBER_OF_SENSORS;
    localparam int HALF = CLOCK_SPEED_HZ / (2 * SPI_FREQUENCY_HZ);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = $clog2(2 * HALF) + 1;
    localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] C_GAP  = CW'(2 * HALF - 1);
    localparam logic [31:0]   RST_PERIOD = 32'(CLOCK_SPEED_HZ / UPDATE_FREQUENCY);
    localparam logic [N-1:0]  ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SHIFT, S_HOLD, S_CHECK, S_GAP, S_NEXT
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_idx, w_idx_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_sck, w_sck_nxt;
    logic [3:0]     r_bit;
    logic [15:0]    r_shift;
    logic [N-1:0]   r_ss_n;
    logic           w_sample, w_start, w_check, w_cnt_zero;

    logic [N-1:0]   r_mask;
    logic [31:0]    r_period, r_tmr;
    logic           r_pend, w_expire;

    logic [12:0]    r_raw    [N];
    logic [15:0]    r_errcnt [N];
    logic [N-1:0]   r_valid, r_ocd, r_perr;
    logic           w_accept, w_perr_ev;
    logic [N-1:0]   w_clr;

    logic           w_first_found, w_up_found;
    logic [IW-1:0]  w_first_idx, w_up_idx;

    logic           r_rd_done;
    logic [31:0]    r_readdata, w_rd_data;
    logic [4:0]     w_sel;
    logic [IW-1:0]  w_ri;
    logic           w_in_range;

`ifdef TLI4970_AVERAGE_EN
    logic [12:0]        r_hist [N][4];
    logic signed [31:0] w_sum;
`endif

    assign ss_n_o          = r_ss_n;
    assign sck             = r_sck;
    assign o_dbg_state     = r_state;
    assign avs.readdata    = r_readdata;
    assign avs.waitrequest = avs.read & ~r_rd_done;
    assign w_cnt_zero      = (r_cnt == '0);

    // Lowest enabled sensor overall, and lowest enabled sensor above the current one.
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = '0;
        w_up_found    = 1'b0;
        w_up_idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = IW'(i);
            end
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_up_found = 1'b1;
                w_up_idx   = IW'(i);
            end
        end
    end

    // Sweep sequencer: next state, sensor index, half-period counter and SCK level.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CW'(1);
        w_sck_nxt   = 1'b0;
        w_sample    = 1'b0;
        w_start     = 1'b0;
        w_check     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend && w_first_found) begin
                    w_state_nxt = S_SELECT;
                    w_idx_nxt   = w_first_idx;
                    w_cnt_nxt   = C_HALF;
                    w_start     = 1'b1;
                end
            end
            S_SELECT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = C_HALF;
                    w_sck_nxt   = 1'b1;
                end
            end
            S_SHIFT: begin
                w_sck_nxt = r_sck;
                if (w_cnt_zero) begin
                    w_cnt_nxt = C_HALF;
                    w_sck_nxt = ~r_sck;
                    if (r_sck) begin
                        w_sample = 1'b1;
                        if (r_bit == 4'd15) w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = S_GAP;
                w_cnt_nxt   = C_GAP;
            end
            S_GAP: begin
                if (w_cnt_zero) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (w_up_found) begin
                    w_state_nxt = S_SELECT;
                    w_idx_nxt   = w_up_idx;
                    w_cnt_nxt   = C_HALF;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer registers; chip select follows the next state so it never glitches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_sck   <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ss_n  <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sck   <= w_sck_nxt;
            if (r_state == S_SELECT) r_bit <= '0;
            else if (w_sample)       r_bit <= r_bit + 4'd1;
            if (w_sample) r_shift <= {r_shift[14:0], miso};
            if (w_state_nxt == S_SELECT || w_state_nxt == S_SHIFT || w_state_nxt == S_HOLD)
                r_ss_n <= ~(ONE << w_idx_nxt);
            else
                r_ss_n <= '1;
        end
    end

    // Period timer; a pending expiry is held until the sequencer starts a sweep.
    assign w_expire = (r_period == '0) || (r_tmr >= r_period - 32'd1);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_tmr <= w_expire ? '0 : r_tmr + 32'd1;
            if (w_expire)     r_pend <= 1'b1;
            else if (w_start) r_pend <= 1'b0;
        end
    end

    // Configuration registers written from the bus.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= '1;
            r_period <= RST_PERIOD;
        end else if (avs.write) begin
            if (avs.address == 8'h80) r_mask   <= avs.writedata[N-1:0];
            if (avs.address == 8'h81) r_period <= avs.writedata;
        end
    end

    // Frame classification: type-1 frames are ignored entirely.
    assign w_accept  = w_check && !r_shift[15] && !(^r_shift);
    assign w_perr_ev = w_check && !r_shift[15] &&  (^r_shift);
    assign w_clr     = (avs.write && avs.address == 8'h82) ? avs.writedata[N-1:0] : '0;

    // Per-sensor data, status and error counters; a bus clear overrides CHECK.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_ocd   <= '0;
            r_perr  <= '0;
            for (int i = 0; i < N; i++) begin
                r_raw[i]    <= '0;
                r_errcnt[i] <= '0;
`ifdef TLI4970_AVERAGE_EN
                for (int k = 0; k < 4; k++) r_hist[i][k] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_accept && r_idx == IW'(i)) begin
                    r_raw[i]   <= r_shift[12:0];
                    r_valid[i] <= 1'b1;
                    r_ocd[i]   <= r_shift[13];
`ifdef TLI4970_AVERAGE_EN
                    r_hist[i][0] <= r_shift[12:0];
                    for (int k = 1; k < 4; k++) r_hist[i][k] <= r_hist[i][k-1];
`endif
                end
                if (w_perr_ev && r_idx == IW'(i)) begin
                    r_perr[i] <= 1'b1;
                    if (r_errcnt[i] != 16'hFFFF) r_errcnt[i] <= r_errcnt[i] + 16'd1;
                end
                if (w_clr[i]) begin
                    r_perr[i]   <= 1'b0;
                    r_errcnt[i] <= '0;
                    r_valid[i]  <= 1'b0;
`ifdef TLI4970_AVERAGE_EN
                    for (int k = 0; k < 4; k++) r_hist[i][k] <= '0;
`endif
                end
            end
        end
    end

    assign w_sel      = avs.address[4:0];
    assign w_ri       = w_sel[IW-1:0];
    assign w_in_range = int'(w_sel) < N;

`ifdef TLI4970_AVERAGE_EN
    assign w_sum = 32'(r_hist[w_ri][0]) + 32'(r_hist[w_ri][1]) + 32'(r_hist[w_ri][2])
                 + 32'(r_hist[w_ri][3]) - 32'(4 * CURRENT_OFFSET);
`endif

    // Read data decode; anything unmapped returns a recognisable marker.
    always_comb begin
        w_rd_data = 32'hDEADBEEF;
        case (avs.address[7:5])
            3'd0: if (w_in_range) w_rd_data = {19'b0, r_raw[w_ri]};
            3'd1: if (w_in_range) w_rd_data = {19'b0, r_raw[w_ri]} - 32'(CURRENT_OFFSET);
            3'd2: if (w_in_range) w_rd_data = {r_errcnt[w_ri], 13'b0, r_perr[w_ri], r_ocd[w_ri], r_valid[w_ri]};
`ifdef TLI4970_AVERAGE_EN
            3'd3: if (w_in_range) w_rd_data = w_sum >>> 2;
`endif
            3'd4: begin
                if (avs.address == 8'h80) w_rd_data = 32'(r_mask);
                if (avs.address == 8'h81) w_rd_data = r_period;
            end
            default: w_rd_data = 32'hDEADBEEF;
        endcase
    end

    // One wait state per read: capture in the first cycle, present in the second.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_done  <= 1'b0;
            r_readdata <= '0;
        end else if (avs.read && !r_rd_done) begin
            r_rd_done  <= 1'b1;
            r_readdata <= w_rd_data;
        end else begin
            r_rd_done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tli4970_array_reader.sv
// Testbench for tli4970_array_reader: register reads checked from a vector
// table, plus hand-written sequences for sweep order, mask changes, parity
// errors, clearing and asynchronous reset. Define TLI4970_AVERAGE_EN for the
// averaging checks.
module tb_tli4970_array_reader;
    localparam int N = 4;

    typedef struct {
        int          phase;
        logic [7:0]  addr;
        logic [31:0] exp;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         miso = 1'b0;
    logic         sck;
    logic [N-1:0] ss_n_o;
    logic [2:0]   dbg_state;

    tli4970_array_reader_if avs();

    tli4970_array_reader #(.NUMBER_OF_SENSORS(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .avs         (avs),
        .ss_n_o      (ss_n_o),
        .miso        (miso),
        .sck         (sck),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog.
    always #10 clock = ~clock;
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           done_cnt [N];
    logic [N-1:0] sel_q [$];
    logic [N-1:0] exp_q [$];
    int           sck_cnt = 0, last_frame_sck = 0, sck_rise = 0, last_rise_cyc = 0;
    int           per_min = 1000000, per_max = 0;
    logic [N-1:0] prev_ss = '1;
    logic         prev_sck = 1'b0;
    logic [15:0]  resp [N];
    logic [15:0]  avg_q [$];
    logic [15:0]  cur_frame = '0;
    int           bit_ptr = -1;
    vec_t         vecs [$];

    // Bus monitor: selection order, completed frames and SCK timing.
    always @(negedge clock) begin
        cyc++;
        if (prev_ss == '1 && ss_n_o != '1) begin
            sel_q.push_back(ss_n_o);
            sck_cnt = 0;
        end
        for (int s = 0; s < N; s++)
            if (!prev_ss[s] && ss_n_o[s]) begin
                done_cnt[s]++;
                last_frame_sck = sck_cnt;
            end
        if (!prev_sck && sck) begin
            sck_cnt++;
            sck_rise++;
            if (sck_cnt > 1) begin
                if (cyc - last_rise_cyc < per_min) per_min = cyc - last_rise_cyc;
                if (cyc - last_rise_cyc > per_max) per_max = cyc - last_rise_cyc;
            end
            last_rise_cyc = cyc;
        end
        prev_ss  = ss_n_o;
        prev_sck = sck;
    end

    // Sensor model: load a frame on chip select, shift it out on rising SCK.
    always @(ss_n_o) begin
        if (ss_n_o != '1) begin
            int sid;
            sid = 0;
            for (int s = 0; s < N; s++) if (!ss_n_o[s]) sid = s;
            if (sid == 0 && avg_q.size() > 0) cur_frame = avg_q.pop_front();
            else                              cur_frame = resp[sid];
            bit_ptr = 15;
        end
    end
    always @(posedge sck) begin
        if (bit_ptr >= 0) begin
            miso = cur_frame[bit_ptr];
            bit_ptr--;
        end
    end

    function automatic logic [15:0] mk_frame(input logic [12:0] v);
        logic [15:0] f;
        f = {3'b000, v};
        f[14] = ^f;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input logic [7:0] a, input logic [31:0] e);
        vec_t v;
        v.phase = p; v.addr = a; v.exp = e;
        vecs.push_back(v);
    endtask

    // Driver tasks.
    task automatic avs_read(input logic [7:0] a, output logic [31:0] d, output int waits);
        @(negedge clock);
        avs.address = a;
        avs.read    = 1'b1;
        waits       = 0;
        #1;
        while (avs.waitrequest && waits < 8) begin
            waits++;
            @(negedge clock);
            #1;
        end
        d        = avs.readdata;
        avs.read = 1'b0;
    endtask

    task automatic avs_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        avs.address   = a;
        avs.writedata = d;
        avs.write     = 1'b1;
        @(negedge clock);
        avs.write     = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input int s, input int target, input string name);
        int t;
        t = 0;
        while (done_cnt[s] < target && t < 20000) begin
            @(negedge clock);
            t++;
        end
        chk(name, 32'(done_cnt[s]), 32'(target));
    endtask

    task automatic wait_ss(input logic [N-1:0] v, input string name);
        int t;
        t = 0;
        while (ss_n_o != v && t < 20000) begin
            @(negedge clock);
            t++;
        end
        chk(name, 32'(ss_n_o), 32'(v));
    endtask

    task automatic run_phase(input int p);
        logic [31:0] d;
        int w;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == p) begin
                avs_read(vecs[i].addr, d, w);
                chk($sformatf("read_p%0d_addr%02h", p, vecs[i].addr), d, vecs[i].exp);
            end
        end
    endtask

    task automatic check_sel(input string name);
        chk({name, "_count"}, 32'(sel_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sel_q.size(); i++)
            chk($sformatf("%s_%0d", name, i), 32'(sel_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        logic [31:0] d;
        int w, b1, b2, b3, b0, rel, n, t;

        // Vector table: {phase, address, expected read data}.
        add(0, 8'h80, 32'h0000000F); add(0, 8'h81, 32'd5000);
        add(0, 8'h00, 32'h0);        add(0, 8'h20, 32'hFFFFF000);
        add(0, 8'h40, 32'h0);        add(0, 8'h43, 32'h0);
        add(1, 8'h00, 32'h1000);     add(1, 8'h20, 32'h0);
        add(1, 8'h40, 32'h1);        add(1, 8'h01, 32'h1000);
        add(1, 8'h03, 32'h1000);     add(1, 8'h23, 32'h0);
        add(1, 8'h43, 32'h1);        add(1, 8'h80, 32'hF);
        add(1, 8'h81, 32'h0);
        add(2, 8'h02, 32'h1123);     add(2, 8'h22, 32'h123);
        add(2, 8'h42, 32'h3);        add(2, 8'h01, 32'h1000);
        add(2, 8'h21, 32'h0);        add(2, 8'h41, 32'h00030004);
        add(2, 8'h03, 32'h1000);     add(2, 8'h43, 32'h1);
        add(2, 8'h80, 32'h0);
        add(3, 8'h41, 32'h0);        add(3, 8'h01, 32'h1000);
        add(3, 8'h42, 32'h3);
        add(5, 8'h04, 32'hDEADBEEF); add(5, 8'h24, 32'hDEADBEEF);
        add(5, 8'h44, 32'hDEADBEEF); add(5, 8'h83, 32'hDEADBEEF);
        add(5, 8'h1F, 32'hDEADBEEF); add(5, 8'hE0, 32'hDEADBEEF);
        add(5, 8'h00, 32'h0);        add(5, 8'h40, 32'h0);
        add(5, 8'h80, 32'hF);        add(5, 8'h81, 32'd5000);
`ifdef TLI4970_AVERAGE_EN
        add(5, 8'h60, 32'hFFFFF000);
        add(6, 8'h60, 32'd6);        add(6, 8'h00, 32'h100C);
`else
        add(5, 8'h60, 32'hDEADBEEF);
`endif

        for (int s = 0; s < N; s++) resp[s] = 16'h5000;
        avs.address = '0; avs.write = 1'b0; avs.writedata = '0; avs.read = 1'b0;

        // Reset block, with a read held across it.
        reset_n = 1'b1;
        #5 reset_n = 1'b0;
        avs.read = 1'b1;
        wait_cycles(3);
        #1;
        chk("reset_ss_n", 32'(ss_n_o), 32'hF);
        chk("reset_sck", 32'(sck), 32'h0);
        chk("reset_readdata", avs.readdata, 32'h0);
        chk("reset_waitrequest", 32'(avs.waitrequest), 32'h1);
        avs.read = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_phase(0);

        // Continuous sweep of all four sensors.
        avs_write(8'h81, 32'h0);
        wait_done(3, 1, "sweep1_done_s3");
        wait_cycles(5);
        exp_q = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        sel_q = sel_q[0:3];
        check_sel("sweep1_order");
        chk("frame_sck_count", 32'(last_frame_sck), 32'd16);
        chk("sck_period_min", 32'(per_min), 32'd50);
        chk("sck_period_max", 32'(per_max), 32'd50);
        run_phase(1);

        // Parity errors on sensor 1, OCD on sensor 2, ignored type-1 on sensor 3.
        avs_write(8'h80, 32'h0);
        wait_cycles(1000);
        resp[1] = 16'h1003;
        resp[2] = 16'h3123;
        resp[3] = 16'h8123;
        avs_write(8'h82, 32'h2);
        b1 = done_cnt[1];
        avs_write(8'h80, 32'hF);
        wait_done(1, b1 + 3, "perr_frames_s1");
        avs_write(8'h80, 32'h0);
        wait_cycles(1000);
        chk("perr_no_extra_frame", 32'(done_cnt[1]), 32'(b1 + 3));
        run_phase(2);
        avs_write(8'h82, 32'h2);
        run_phase(3);

        // Mask change in the middle of sensor 1's frame.
        for (int s = 0; s < N; s++) resp[s] = 16'h5000;
        avs_write(8'h80, 32'hF);
        wait_ss(4'b1101, "mask_wait_s1");
        wait_cycles(100);
        avs_write(8'h80, 32'h5);
        sel_q.delete();
        b1 = done_cnt[1]; b2 = done_cnt[2]; b3 = done_cnt[3];
        wait_done(1, b1 + 1, "mask_s1_completes");
        chk("mask_s1_sck_count", 32'(last_frame_sck), 32'd16);
        wait_done(2, b2 + 2, "mask_s2_twice");
        avs_write(8'h80, 32'h0);
        chk("mask_s1_once", 32'(done_cnt[1]), 32'(b1 + 1));
        chk("mask_s3_skipped", 32'(done_cnt[3]), 32'(b3));
        exp_q = '{4'b1011, 4'b1110, 4'b1011};
        check_sel("mask5_order");
        wait_cycles(1000);
        n = sel_q.size();
        wait_cycles(2000);
        chk("mask0_no_select", 32'(sel_q.size()), 32'(n));
        chk("mask0_ss_idle", 32'(ss_n_o), 32'hF);

        // Asynchronous reset during bit 7 of sensor 0's frame.
        avs_write(8'h80, 32'hF);
        wait_ss(4'b1110, "rst_wait_s0");
        b0 = sck_rise;
        t = 0;
        while (sck_rise < b0 + 8 && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("rst_reach_bit7", 32'(sck_rise - b0), 32'd8);
        wait_cycles(10);
        #3;
        chk("rst_mid_frame_sck_high", 32'(sck), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_ss_n", 32'(ss_n_o), 32'hF);
        chk("rst_async_sck", 32'(sck), 32'h0);
        wait_cycles(5);
        reset_n = 1'b1;
        rel = cyc;
        avs_read(8'h99, d, w);
        chk("unmapped_0x99_data", d, 32'hDEADBEEF);
        chk("unmapped_0x99_waits", 32'(w), 32'd1);
        run_phase(5);
        t = 0;
        while (ss_n_o == '1 && t < 8000) begin
            @(negedge clock);
            t++;
        end
        chk("restart_sensor0", 32'(ss_n_o), 32'hE);
        checks++;
        if (cyc - rel < 4999 || cyc - rel > 5003) begin
            errors++;
            $display("FAIL restart_delay: got %0d cycles expected 4999..5003", cyc - rel);
        end

`ifdef TLI4970_AVERAGE_EN
        // Four accepted samples on sensor 0 feed the average.
        avs_write(8'h80, 32'h0);
        wait_cycles(1500);
        avs_write(8'h82, 32'h1);
        avs_write(8'h81, 32'h0);
        avg_q.push_back(mk_frame(13'd4096));
        avg_q.push_back(mk_frame(13'd4100));
        avg_q.push_back(mk_frame(13'd4104));
        avg_q.push_back(mk_frame(13'd4108));
        b0 = done_cnt[0];
        avs_write(8'h80, 32'h1);
        wait_done(0, b0 + 4, "avg_frames_s0");
        avs_write(8'h80, 32'h0);
        wait_cycles(1000);
        run_phase(6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
